// File: rtl/reflet_split_access_unit_if.sv
// reflet_split_access_unit_if: CPU-side request/response and RAM-side bus of the split access unit.
interface reflet_split_access_unit_if #(
   parameter int word_size = 32,
   parameter int addr_size = 32
);
   logic                         cpu_req;
   logic [$clog2(word_size/8):0] size_used;
   logic [addr_size-1:0]         cpu_addr;
   logic [word_size-1:0]         cpu_data_out;
   logic                         cpu_write_en;
   logic [word_size-1:0]         cpu_data_in;
   logic                         busy;
   logic                         ready;
   logic                         alignement_error;
   logic [addr_size-1:0]         ram_addr;
   logic [word_size-1:0]         ram_data_out;
   logic [word_size-1:0]         ram_data_in;
   logic                         ram_write_en;
   modport master (
      output cpu_req, size_used, cpu_addr, cpu_data_out, cpu_write_en, ram_data_in,
      input  cpu_data_in, busy, ready, alignement_error, ram_addr, ram_data_out, ram_write_en
   );
   modport slave (
      input  cpu_req, size_used, cpu_addr, cpu_data_out, cpu_write_en, ram_data_in,
      output cpu_data_in, busy, ready, alignement_error, ram_addr, ram_data_out, ram_write_en
   );
endinterface

// File: rtl/reflet_split_access_unit.sv
// reflet_split_access_unit: byte-granular loads/stores on a word RAM, splitting word-crossing
// accesses into two transactions and doing partial stores as read-modify-write.
module reflet_split_access_unit #(
   parameter int word_size    = 32,
   parameter int addr_size    = 32,
   parameter bit strict_align = 1'b0
) (
   input logic                     clk,
   input logic                     reset,
   reflet_split_access_unit_if.slave bus
);
   localparam int wb  = word_size / 8;
   localparam int lwb = $clog2(wb);
   localparam logic [2:0] idle = 3'd0, rd_lo = 3'd1, rd_hi = 3'd2, wr_lo = 3'd3, wr_hi = 3'd4, done = 3'd5;
   logic [2:0]             state, nxt;
   logic                   ph, w_r, err_r, w_c, span, err_c, full;
   logic [addr_size-1:0]   a_r, a_c, base, base2;
   logic [word_size-1:0]   d_r, d_c, lo_buf, hi_buf, lo_n, hi_n, mask, ld;
   logic [lwb:0]           s_r, s_c;
   logic [lwb-1:0]         off;
   logic [lwb+2:0]         sh;
   logic [31:0]            n;
   logic [2*word_size-1:0] merged;
   // In IDLE the live request is decoded so the first transaction can be set up on the capture edge.
   always_comb begin
      a_c    = state == idle ? bus.cpu_addr : a_r;
      d_c    = state == idle ? bus.cpu_data_out : d_r;
      s_c    = state == idle ? bus.size_used : s_r;
      w_c    = state == idle ? bus.cpu_write_en : w_r;
      n      = 32'd1 << s_c;
      off    = a_c[lwb-1:0];
      sh     = {off, 3'b000};
      base   = {a_c[addr_size-1:lwb], {lwb{1'b0}}};
      base2  = base + addr_size'(wb);
      span   = 32'(off) + n > 32'(wb);
      err_c  = 32'(s_c) > 32'(lwb) || (strict_align && (32'(off) & (n - 32'd1)) != 32'd0);
      full   = w_c && off == '0 && 32'(s_c) == 32'(lwb);
      mask   = ~({word_size{1'b1}} << (n << 3));
      lo_n   = state == rd_lo && ph ? bus.ram_data_in : lo_buf;
      hi_n   = state == rd_hi && ph ? bus.ram_data_in : hi_buf;
      ld     = word_size'({hi_n, lo_n} >> sh) & mask;
      merged = ({hi_n, lo_n} & ~({{word_size{1'b0}}, mask} << sh)) | ({{word_size{1'b0}}, d_c & mask} << sh);
      nxt    = state == idle  ? (bus.cpu_req ? (err_c ? done : full ? wr_lo : rd_lo) : idle)
             : state == rd_lo ? (!ph ? rd_lo : span ? rd_hi : w_c ? wr_lo : done)
             : state == rd_hi ? (!ph ? rd_hi : w_c ? wr_lo : done)
             : state == wr_lo ? (span ? wr_hi : done)
             : state == wr_hi ? done : idle;
   end
   assign bus.busy             = state != idle;
   assign bus.ready            = state == done;
   assign bus.alignement_error = state == done && err_r;
   assign bus.ram_write_en     = state == wr_lo || state == wr_hi;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state            <= idle;
         ph               <= 1'b0;
         a_r              <= '0;
         d_r              <= '0;
         s_r              <= '0;
         w_r              <= 1'b0;
         err_r            <= 1'b0;
         lo_buf           <= '0;
         hi_buf           <= '0;
         bus.cpu_data_in  <= '0;
         bus.ram_addr     <= '0;
         bus.ram_data_out <= '0;
      end else begin
         state  <= nxt;
         ph     <= (state == rd_lo || state == rd_hi) && !ph;
         lo_buf <= lo_n;
         hi_buf <= hi_n;
         if (state == idle && bus.cpu_req) begin
            a_r   <= bus.cpu_addr;
            d_r   <= bus.cpu_data_out;
            s_r   <= bus.size_used;
            w_r   <= bus.cpu_write_en;
            err_r <= err_c;
         end
         if (nxt != state && (nxt == rd_lo || nxt == wr_lo)) bus.ram_addr <= base;
         if (nxt != state && (nxt == rd_hi || nxt == wr_hi)) bus.ram_addr <= base2;
         if (nxt == wr_lo) bus.ram_data_out <= merged[word_size-1:0];
         if (nxt == wr_hi) bus.ram_data_out <= merged[2*word_size-1:word_size];
         if ((state == rd_lo || state == rd_hi) && nxt == done) bus.cpu_data_in <= ld;
      end
endmodule

// File: tb/tb_reflet_split_access_unit.sv
// tb_reflet_split_access_unit: directed and randomized checks of the split access unit against a byte-level memory model.
module tb_reflet_split_access_unit;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   logic req = 1'b0, wr = 1'b0, sel = 1'b0;
   logic [2:0] sz = '0;
   logic [31:0] addr = '0, data = '0;
   int total = 0, bad = 0, wr_cnt = 0, wr1_cnt = 0;
   logic [31:0] rd_q[$];
   logic [31:0] mem [256];
   bit [7:0] ref_b [bit [31:0]];
   logic [31:0] model_q = '0;
   reflet_split_access_unit_if #(.word_size(32), .addr_size(32)) i0 (), i1 ();
   reflet_split_access_unit #(.word_size(32), .addr_size(32), .strict_align(1'b0)) dut0 (.clk(clk), .reset(rst_n), .bus(i0.slave));
   reflet_split_access_unit #(.word_size(32), .addr_size(32), .strict_align(1'b1)) dut1 (.clk(clk), .reset(rst_n), .bus(i1.slave));
   assign i0.cpu_req = req && !sel;
   assign i1.cpu_req = req && sel;
   assign i0.size_used = sz;
   assign i1.size_used = sz;
   assign i0.cpu_addr = addr;
   assign i1.cpu_addr = addr;
   assign i0.cpu_data_out = data;
   assign i1.cpu_data_out = data;
   assign i0.cpu_write_en = wr;
   assign i1.cpu_write_en = wr;
   assign i1.ram_data_in = '0;
   // RAM with one-cycle read latency; only addresses used by the bench are distinct in bits [9:2].
   always @(posedge clk) begin
      i0.ram_data_in <= mem[i0.ram_addr[9:2]];
      if (i0.ram_write_en) begin
         mem[i0.ram_addr[9:2]] <= i0.ram_data_out;
         wr_cnt <= wr_cnt + 1;
      end
      if (i1.ram_write_en) wr1_cnt <= wr1_cnt + 1;
      if (i0.busy && !i0.ready && !i0.ram_write_en && (rd_q.size() == 0 || rd_q[$] != i0.ram_addr))
         rd_q.push_back(i0.ram_addr);
   end
   initial begin
      #1000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
   function automatic logic [31:0] refw(input logic [31:0] a);
      logic [31:0] v;
      for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_b.exists(a + 32'(i)) ? ref_b[a + 32'(i)] : 8'h00;
      return v;
   endfunction
   task automatic preload(input logic [31:0] a, input logic [31:0] v);
      mem[a[9:2]] = v;
      for (int i = 0; i < 4; i++) ref_b[a + 32'(i)] = v[8*i +: 8];
   endtask
   task automatic model(input logic [31:0] a, input logic [2:0] z, input bit w, input logic [31:0] d, input bit strict,
                        output int lat, output bit er, output int nw);
      int n = 1 << z;
      int off = int'(a[1:0]);
      bit sp = off + n > 4;
      er  = n > 4 || (strict && (a % n) != 0);
      lat = er ? 1 : (w && off == 0 && n == 4) ? 2 : w ? (sp ? 7 : 4) : (sp ? 5 : 3);
      nw  = (er || !w) ? 0 : sp ? 2 : 1;
      if (!er && w) for (int i = 0; i < n; i++) ref_b[a + 32'(i)] = d[8*i +: 8];
      if (!er && !w) begin
         model_q = '0;
         for (int i = 0; i < n; i++) model_q[8*i +: 8] = ref_b.exists(a + 32'(i)) ? ref_b[a + 32'(i)] : 8'h00;
      end
   endtask
   task automatic run(input bit s, input logic [31:0] a, input logic [2:0] z, input bit w, input logic [31:0] d,
                      output int lat, output bit er, output logic [31:0] q, output int nw);
      int w0;
      @(negedge clk);
      sel = s; addr = a; sz = z; wr = w; data = d; req = 1'b1;
      w0 = s ? wr1_cnt : wr_cnt;
      rd_q.delete();
      @(posedge clk);
      #1 req = 1'b0; addr = $urandom; data = $urandom; wr = ~w;
      lat = 1;
      while (!(s ? i1.ready : i0.ready) && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      er = s ? i1.alignement_error : i0.alignement_error;
      q  = s ? i1.cpu_data_in : i0.cpu_data_in;
      @(posedge clk);
      #1 nw = (s ? wr1_cnt : wr_cnt) - w0;
   endtask
   task automatic test_reset();
      #12;
      total++;
      if ({i0.busy, i0.ready, i0.alignement_error, i0.ram_write_en, i0.cpu_data_in, i0.ram_addr, i0.ram_data_out} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got busy=%b ready=%b err=%b we=%b q=%h ra=%h rd=%h want all zero", i0.busy, i0.ready,
                  i0.alignement_error, i0.ram_write_en, i0.cpu_data_in, i0.ram_addr, i0.ram_data_out);
      end
      total++;
      if ({i1.busy, i1.ready, i1.alignement_error, i1.ram_write_en} !== 4'b0) begin
         bad++;
         $display("FAIL reset_outputs_strict got %b want 0000", {i1.busy, i1.ready, i1.alignement_error, i1.ram_write_en});
      end
      @(negedge clk) rst_n = 1'b1;
   endtask
   task automatic test_span_load();
      int lat, el, nw, en; bit er, ee; logic [31:0] q;
      preload(32'h10, 32'h44332211);
      preload(32'h14, 32'h88776655);
      model(32'h12, 3'd2, 1'b0, 32'h0, 1'b0, el, ee, en);
      run(1'b0, 32'h12, 3'd2, 1'b0, 32'h0, lat, er, q, nw);
      total++; if (lat !== 5) begin bad++; $display("FAIL span_load_latency got %0d want 5", lat); end
      total++; if (q !== 32'h66554433) begin bad++; $display("FAIL span_load_data got %h want 66554433", q); end
      total++;
      if (rd_q.size() != 2 || rd_q[0] !== 32'h10 || rd_q[1] !== 32'h14) begin
         bad++; $display("FAIL span_load_read_addrs got %p want 10,14", rd_q);
      end
      total++; if (nw !== 0) begin bad++; $display("FAIL span_load_writes got %0d want 0", nw); end
   endtask
   task automatic test_byte_store();
      int lat, el, nw, en; bit er, ee; logic [31:0] q;
      model(32'h11, 3'd0, 1'b1, 32'hFFFFFFAB, 1'b0, el, ee, en);
      run(1'b0, 32'h11, 3'd0, 1'b1, 32'hFFFFFFAB, lat, er, q, nw);
      total++; if (lat !== 4) begin bad++; $display("FAIL byte_store_latency got %0d want 4", lat); end
      total++; if (nw !== 1) begin bad++; $display("FAIL byte_store_writes got %0d want 1", nw); end
      total++; if (mem[8'h04] !== 32'h4433AB11) begin bad++; $display("FAIL byte_store_word got %h want 4433ab11", mem[8'h04]); end
      total++; if (mem[8'h05] !== 32'h88776655) begin bad++; $display("FAIL byte_store_neighbour got %h want 88776655", mem[8'h05]); end
      total++; if (q !== 32'h66554433) begin bad++; $display("FAIL byte_store_keeps_load got %h want 66554433", q); end
   endtask
   task automatic test_span_store();
      int lat, el, nw, en; bit er, ee; logic [31:0] q;
      preload(32'h10, 32'h44332211);
      model(32'h13, 3'd1, 1'b1, 32'h1234BEEF, 1'b0, el, ee, en);
      run(1'b0, 32'h13, 3'd1, 1'b1, 32'h1234BEEF, lat, er, q, nw);
      total++; if (lat !== 7) begin bad++; $display("FAIL span_store_latency got %0d want 7", lat); end
      total++; if (nw !== 2) begin bad++; $display("FAIL span_store_writes got %0d want 2", nw); end
      total++; if (mem[8'h04] !== 32'hEF332211) begin bad++; $display("FAIL span_store_lo got %h want ef332211", mem[8'h04]); end
      total++; if (mem[8'h05] !== 32'h887766BE) begin bad++; $display("FAIL span_store_hi got %h want 887766be", mem[8'h05]); end
   endtask
   task automatic test_full_store();
      int lat, el, nw, en; bit er, ee; logic [31:0] q;
      model(32'h20, 3'd2, 1'b1, 32'hDEADBEEF, 1'b0, el, ee, en);
      run(1'b0, 32'h20, 3'd2, 1'b1, 32'hDEADBEEF, lat, er, q, nw);
      total++; if (lat !== 2) begin bad++; $display("FAIL full_store_latency got %0d want 2", lat); end
      total++; if (nw !== 1) begin bad++; $display("FAIL full_store_writes got %0d want 1", nw); end
      total++; if (rd_q.size() != 0) begin bad++; $display("FAIL full_store_reads got %0d reads want 0", rd_q.size()); end
      total++; if (mem[8'h08] !== 32'hDEADBEEF) begin bad++; $display("FAIL full_store_word got %h want deadbeef", mem[8'h08]); end
   endtask
   task automatic test_strict();
      int lat, el, nw, en; bit er, ee; logic [31:0] q;
      model(32'h01, 3'd1, 1'b0, 32'h0, 1'b1, el, ee, en);
      run(1'b1, 32'h01, 3'd1, 1'b0, 32'h0, lat, er, q, nw);
      total++; if (lat !== el) begin bad++; $display("FAIL strict_latency got %0d want %0d", lat, el); end
      total++; if (er !== 1'b1) begin bad++; $display("FAIL strict_error got %b want 1", er); end
      total++; if (nw !== 0) begin bad++; $display("FAIL strict_writes got %0d want 0", nw); end
      total++; if (q !== 32'h0) begin bad++; $display("FAIL strict_data got %h want 0", q); end
      total++;
      if (i1.ready !== 1'b0 || i1.alignement_error !== 1'b0 || i1.busy !== 1'b0) begin
         bad++; $display("FAIL strict_pulse_width got ready=%b err=%b busy=%b want 000", i1.ready, i1.alignement_error, i1.busy);
      end
      preload(32'h0, 32'hA0B0C0D0);
      model(32'h01, 3'd1, 1'b0, 32'h0, 1'b0, el, ee, en);
      run(1'b0, 32'h01, 3'd1, 1'b0, 32'h0, lat, er, q, nw);
      total++; if (er !== 1'b0 || lat !== 3) begin bad++; $display("FAIL lax_misaligned got err=%b lat=%0d want err=0 lat=3", er, lat); end
      total++; if (q !== 32'h0000B0C0) begin bad++; $display("FAIL lax_misaligned_data got %h want 0000b0c0", q); end
   endtask
   task automatic test_oversize();
      int lat, el, nw, en; bit er, ee; logic [31:0] q;
      for (int s = 0; s < 2; s++) begin
         model(32'h40, 3'd3, 1'b1, 32'h55555555, bit'(s), el, ee, en);
         run(bit'(s), 32'h40, 3'd3, 1'b1, 32'h55555555, lat, er, q, nw);
         total++; if (er !== 1'b1 || lat !== 1) begin bad++; $display("FAIL oversize_error s=%0d got err=%b lat=%0d want err=1 lat=1", s, er, lat); end
         total++; if (nw !== 0) begin bad++; $display("FAIL oversize_writes s=%0d got %0d want 0", s, nw); end
         total++; if (q !== (s == 0 ? model_q : 32'h0)) begin bad++; $display("FAIL oversize_data_held s=%0d got %h", s, q); end
      end
   endtask
   task automatic test_wrap();
      int lat, el, nw, en; bit er, ee; logic [31:0] q;
      preload(32'hFFFFFFFC, 32'h11223344);
      preload(32'h0, 32'h55667788);
      model(32'hFFFFFFFE, 3'd2, 1'b1, 32'hA1B2C3D4, 1'b0, el, ee, en);
      run(1'b0, 32'hFFFFFFFE, 3'd2, 1'b1, 32'hA1B2C3D4, lat, er, q, nw);
      total++; if (lat !== 7 || nw !== 2) begin bad++; $display("FAIL wrap_store got lat=%0d writes=%0d want 7 and 2", lat, nw); end
      total++; if (mem[8'hFF] !== 32'hC3D43344) begin bad++; $display("FAIL wrap_store_lo got %h want c3d43344", mem[8'hFF]); end
      total++; if (mem[8'h00] !== 32'h5566A1B2) begin bad++; $display("FAIL wrap_store_hi got %h want 5566a1b2", mem[8'h00]); end
      model(32'hFFFFFFFE, 3'd2, 1'b0, 32'h0, 1'b0, el, ee, en);
      run(1'b0, 32'hFFFFFFFE, 3'd2, 1'b0, 32'h0, lat, er, q, nw);
      total++;
      if (rd_q.size() != 2 || rd_q[0] !== 32'hFFFFFFFC || rd_q[1] !== 32'h0) begin
         bad++; $display("FAIL wrap_load_read_addrs got %p want fffffffc,0", rd_q);
      end
      total++; if (q !== 32'hA1B2C3D4) begin bad++; $display("FAIL wrap_load_data got %h want a1b2c3d4", q); end
   endtask
   task automatic test_reset_mid_write();
      int k, w0;
      preload(32'h30, 32'h01020304);
      @(negedge clk);
      sel = 1'b0; addr = 32'h31; sz = 3'd0; wr = 1'b1; data = 32'h000000EE; req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      k = 0;
      while (!i0.ram_write_en && k < 10) begin
         @(posedge clk);
         #1 k++;
      end
      total++; if (i0.ram_write_en !== 1'b1) begin bad++; $display("FAIL rst_mid_reach_write got we=%b want 1", i0.ram_write_en); end
      w0 = wr_cnt;
      #2 rst_n = 1'b0;
      #1;
      total++; if (i0.ram_write_en !== 1'b0 || i0.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_drop got we=%b busy=%b want 0 0", i0.ram_write_en, i0.busy); end
      @(negedge clk) rst_n = 1'b1;
      model_q = '0;
      repeat (4) @(posedge clk);
      #1;
      total++; if (i0.busy !== 1'b0 || i0.ready !== 1'b0) begin bad++; $display("FAIL rst_mid_idle got busy=%b ready=%b want 0 0", i0.busy, i0.ready); end
      total++; if (wr_cnt !== w0 || mem[8'h0C] !== 32'h01020304) begin bad++; $display("FAIL rst_mid_no_write got writes=%0d word=%h want 0 01020304", wr_cnt - w0, mem[8'h0C]); end
   endtask
   task automatic test_random();
      int lat, el, nw, en; bit er, ee; logic [31:0] q, a, d, b; logic [2:0] z; bit w;
      for (int i = 0; i < 16; i++) preload(32'h100 + 32'(4 * i), $urandom);
      preload(32'hFFFFFFF8, $urandom);
      preload(32'hFFFFFFFC, $urandom);
      preload(32'h0, $urandom);
      for (int t = 0; t < 150; t++) begin
         a = $urandom_range(0, 7) == 0 ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : 32'h100 + 32'($urandom_range(0, 59));
         z = $urandom_range(0, 9) == 0 ? 3'd3 : 3'($urandom_range(0, 2));
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         b = {a[31:2], 2'b00};
         model(a, z, w, d, 1'b0, el, ee, en);
         run(1'b0, a, z, w, d, lat, er, q, nw);
         total++;
         if (lat !== el || er !== ee || nw !== en) begin
            bad++; $display("FAIL rand_timing t=%0d a=%h z=%0d w=%b got lat=%0d err=%b wr=%0d want %0d %b %0d", t, a, z, w, lat, er, nw, el, ee, en);
         end
         total++; if (q !== model_q) begin bad++; $display("FAIL rand_data t=%0d a=%h z=%0d w=%b got %h want %h", t, a, z, w, q, model_q); end
         total++;
         if (mem[b[9:2]] !== refw(b) || mem[8'(b[9:2] + 8'd1)] !== refw(b + 32'd4)) begin
            bad++; $display("FAIL rand_mem t=%0d a=%h got %h %h want %h %h", t, a, mem[b[9:2]], mem[8'(b[9:2] + 8'd1)], refw(b), refw(b + 32'd4));
         end
      end
   endtask
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      test_reset();
      test_span_load();
      test_byte_store();
      test_span_store();
      test_full_store();
      test_strict();
      test_oversize();
      test_wrap();
      test_reset_mid_write();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
